// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : arb_pkg
// Shared arbiter state type and a one-hot decode helper.
// Rev    : 1.0
// ============================================================================
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Callers truncate the result to their own requester count (at most 16).
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'b1 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Rotated priority encoder: lowest request above 'last', else lowest overall.
// Rev    : 1.0
// ============================================================================
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          found
);

  logic [IW-1:0] w_hi_idx;
  logic [IW-1:0] w_lo_idx;
  logic          w_hi_found;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    found      = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_lo_idx = IW'(i);
        found    = 1'b1;
        if (i > int'(last)) begin
          w_hi_idx   = IW'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    winner = w_hi_found ? w_hi_idx : w_lo_idx;
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Round-robin arbiter with registered one-hot grant held until release.
// Optional forced release after TIMEOUT cycles when ARB_TIMEOUT_EN is defined.
// Rev    : 1.0
// ============================================================================
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 srst_n_i,
  input  logic [N-1:0]         req_i,
  input  logic                 done_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_id_o,
  output logic                 gnt_val_o
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                 timeout_o
`endif
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 16 || TIMEOUT < 2) begin : g_bad_params
    $error("rr_arbiter: N must be 2..16 and TIMEOUT at least 2");
  end

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  w_gnt_nxt;
  logic [IW-1:0] r_gnt_id;
  logic [IW-1:0] w_id_nxt;
  logic [IW-1:0] r_last;
  logic [IW-1:0] w_last_nxt;
  logic [IW-1:0] w_winner;
  logic          w_found;
  logic          w_user_release;
  logic          w_forced;
  logic          w_release;
  logic          w_load;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req_i),
    .last   (r_last),
    .winner (w_winner),
    .found  (w_found)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  assign w_forced  = (r_state == BUSY) && !w_user_release && (r_cnt == CW'(TIMEOUT - 1));
  assign timeout_o = r_timeout;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_forced;
      if (r_state == BUSY && !w_release) r_cnt <= r_cnt + 1'b1;
      else                               r_cnt <= '0;
    end
  end
`else
  assign w_forced = 1'b0;
`endif

  // The holder is already at 'last', so it naturally ranks lowest on re-arbitration.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_id_nxt       = r_gnt_id;
    w_last_nxt     = r_last;
    w_user_release = done_i || !req_i[r_gnt_id];
    w_release      = (r_state == BUSY) && (w_user_release || w_forced);
    w_load         = w_found && ((r_state == IDLE) || w_release);
    if (w_load) begin
      w_gnt_nxt   = N'(onehot16(4'(w_winner)));
      w_id_nxt    = w_winner;
      w_last_nxt  = w_winner;
      w_state_nxt = BUSY;
    end else if (w_release) begin
      w_gnt_nxt   = '0;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_last   <= IW'(N - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_id_nxt;
      r_last   <= w_last_nxt;
    end
  end

  assign gnt_o     = r_gnt;
  assign gnt_id_o  = r_gnt_id;
  assign gnt_val_o = |r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_rr_arbiter
// Scoreboard bench for rr_arbiter (N=4, TIMEOUT=8), directed plus random phase.
// Rev    : 1.0
// ============================================================================
module tb_rr_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       srst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_val;
  logic       timeout;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;
  bit   rand_phase = 1'b0;
  int   wt[4];
  logic [3:0] prev_gnt = '0;

  always #5 clk = ~clk;

  rr_arbiter #(.N(4), .TIMEOUT(8)) dut (
    .clk_i     (clk),
    .srst_n_i  (srst_n),
    .req_i     (req),
    .done_i    (done),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .gnt_val_o (gnt_val)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_o (timeout)
`endif
  );

`ifndef ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic cyc(input logic rn, input logic [3:0] r, input logic d,
                     input logic [3:0] eg, input logic [1:0] eid, input logic eto);
    srst_n = rn;
    req    = r;
    done   = d;
    exp_q.push_back('{gnt: eg, id: eid, to: eto});
    @(negedge clk);
  endtask

  // Monitor: scoreboard pops during directed phase, invariants during random phase.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vec++;
        total++;
        if (gnt !== e.gnt || gnt_id !== e.id || gnt_val !== (|e.gnt)) begin
          bad++;
          $display("FAIL vec%0d grant: got gnt=%b id=%0d val=%b, want gnt=%b id=%0d val=%b",
                   vec, gnt, gnt_id, gnt_val, e.gnt, e.id, |e.gnt);
        end
`ifdef ARB_TIMEOUT_EN
        total++;
        if (timeout !== e.to) begin
          bad++;
          $display("FAIL vec%0d timeout: got %b, want %b", vec, timeout, e.to);
        end
`endif
      end
      if (rand_phase) begin
        total++;
        if (gnt_val ? !$onehot(gnt) : (gnt !== 4'b0)) begin
          bad++;
          $display("FAIL onehot: got gnt=%b val=%b, want one-hot iff val", gnt, gnt_val);
        end
        total++;
        if (gnt_val !== (|gnt) || (gnt_val && gnt !== (4'b0001 << gnt_id))) begin
          bad++;
          $display("FAIL id_match: got gnt=%b id=%0d val=%b, want gnt=onehot(id)", gnt, gnt_id, gnt_val);
        end
        if (gnt_val && gnt != prev_gnt) begin
          for (int i = 0; i < 4; i++) begin
            if (gnt[i]) wt[i] = 0;
            else if (req[i]) begin
              wt[i]++;
              total++;
              if (wt[i] > 4) begin
                bad++;
                $display("FAIL starve%0d: got %0d grants passed, want at most 4", i, wt[i]);
              end
            end
          end
        end
        for (int i = 0; i < 4; i++) if (!req[i]) wt[i] = 0;
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) wt[i] = 0;
    // reset
    cyc(0, 4'b0000, 0, 4'b0000, 2'd0, 0);
    cyc(0, 4'b1111, 1, 4'b0000, 2'd0, 0);
    // all requesting, done every 2nd cycle: 0,1,2,3,0 back-to-back
    cyc(1, 4'b1111, 0, 4'b0001, 2'd0, 0);
    cyc(1, 4'b1111, 0, 4'b0001, 2'd0, 0);
    cyc(1, 4'b1111, 1, 4'b0010, 2'd1, 0);
    cyc(1, 4'b1111, 0, 4'b0010, 2'd1, 0);
    cyc(1, 4'b1111, 1, 4'b0100, 2'd2, 0);
    cyc(1, 4'b1111, 0, 4'b0100, 2'd2, 0);
    cyc(1, 4'b1111, 1, 4'b1000, 2'd3, 0);
    cyc(1, 4'b1111, 0, 4'b1000, 2'd3, 0);
    cyc(1, 4'b1111, 1, 4'b0001, 2'd0, 0);
    cyc(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
    // single pulse request, withdrawn -> idle, id holds
    cyc(1, 4'b0100, 0, 4'b0100, 2'd2, 0);
    cyc(1, 4'b0000, 0, 4'b0000, 2'd2, 0);
    // holder 2 with 0 pending: wrap to 0; 2 regranted only when alone
    cyc(1, 4'b0100, 0, 4'b0100, 2'd2, 0);
    cyc(1, 4'b0101, 0, 4'b0100, 2'd2, 0);
    cyc(1, 4'b0101, 1, 4'b0001, 2'd0, 0);
    cyc(1, 4'b0101, 1, 4'b0100, 2'd2, 0);
    cyc(1, 4'b0100, 1, 4'b0100, 2'd2, 0);
    cyc(1, 4'b0101, 1, 4'b0001, 2'd0, 0);
    cyc(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
    // reset during BUSY, pointer back to 3
    cyc(1, 4'b1000, 0, 4'b1000, 2'd3, 0);
    cyc(1, 4'b1000, 0, 4'b1000, 2'd3, 0);
    cyc(0, 4'b1000, 0, 4'b0000, 2'd0, 0);
    cyc(1, 4'b1010, 0, 4'b0010, 2'd1, 0);
    cyc(1, 4'b0000, 0, 4'b0000, 2'd1, 0);
    // done while idle ignored; late requests do not disturb holder
    cyc(1, 4'b0000, 1, 4'b0000, 2'd1, 0);
    cyc(1, 4'b0001, 0, 4'b0001, 2'd0, 0);
    cyc(1, 4'b1111, 0, 4'b0001, 2'd0, 0);
    cyc(1, 4'b1110, 1, 4'b0010, 2'd1, 0);
    cyc(1, 4'b0000, 0, 4'b0000, 2'd1, 0);
    // held grant with no done: forced release after 8 cycles only when enabled
    cyc(1, 4'b0011, 0, 4'b0001, 2'd0, 0);
    for (int k = 0; k < 7; k++) cyc(1, 4'b0011, 0, 4'b0001, 2'd0, 0);
`ifdef ARB_TIMEOUT_EN
    cyc(1, 4'b0011, 0, 4'b0010, 2'd1, 1);
    cyc(1, 4'b0011, 0, 4'b0010, 2'd1, 0);
    cyc(1, 4'b0000, 0, 4'b0000, 2'd1, 0);
`else
    cyc(1, 4'b0011, 0, 4'b0001, 2'd0, 0);
    cyc(1, 4'b0011, 0, 4'b0001, 2'd0, 0);
    cyc(1, 4'b0000, 0, 4'b0000, 2'd0, 0);
`endif

    // random phase: requests held until served, holder may drop on done
    rand_phase = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] r;
      logic       d;
      r = req;
      d = gnt_val && ($urandom_range(0, 2) == 0);
      if (d && ($urandom_range(0, 1) == 1)) r[gnt_id] = 1'b0;
      for (int i = 0; i < 4; i++)
        if (!r[i] && $urandom_range(0, 3) == 0) r[i] = 1'b1;
      srst_n = 1'b1;
      req    = r;
      done   = d;
      @(negedge clk);
    end
    rand_phase = 1'b0;
    req  = '0;
    done = 1'b0;
    @(negedge clk);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
